vga_scan_controller: RTL and testbench

- Downstream/timing neighbour of the pong pixel generator.
- Owns the raster: produces the PIXEL_H/PIXEL_V coordinates the game engine renders against.
- Consumes the registered 3-bit PIXEL the engine returns, aligns it with delayed sync/blank, and drives the VGA pins.
- Also emits a one-cycle vertical-blank pulse that game logic uses as a frame tick.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_scan_controller_if.sv | 26 ++
 rtl/vga_delay_line.sv | 40 ++++
 rtl/vga_scan_controller.sv | 119 +++++++++++
 tb/tb_vga_scan_controller.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constant sets and colour bit positions for the raster
// controller and its neighbours.
package vga_timing_pkg;

  // 800x600 @ 72 Hz, 50 MHz pixel clock
  localparam int VGA800_H_VISIBLE = 800;
  localparam int VGA800_H_FRONT   = 56;
  localparam int VGA800_H_SYNC    = 120;
  localparam int VGA800_H_BACK    = 64;
  localparam int VGA800_V_VISIBLE = 600;
  localparam int VGA800_V_FRONT   = 37;
  localparam int VGA800_V_SYNC    = 6;
  localparam int VGA800_V_BACK    = 23;
  localparam bit VGA800_HS_POL    = 1'b1;
  localparam bit VGA800_VS_POL    = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam bit VGA640_HS_POL    = 1'b0;
  localparam bit VGA640_VS_POL    = 1'b0;

  localparam int RED   = 2;
  localparam int GREEN = 1;
  localparam int BLUE  = 0;

endpackage

// File: rtl/vga_scan_controller_if.sv
// Signal bundle between the raster controller (master) and the game engine /
// VGA pin consumer (slave).
interface vga_scan_controller_if;
  logic [2:0]  PIXEL;
  logic [10:0] PIXEL_H;
  logic [10:0] PIXEL_V;
  logic        ACTIVE;
  logic        VBLANK_START;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_R;
  logic        VGA_G;
  logic        VGA_B;

  modport master (
    input  PIXEL,
    output PIXEL_H, PIXEL_V, ACTIVE, VBLANK_START,
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output PIXEL,
    input  PIXEL_H, PIXEL_V, ACTIVE, VBLANK_START,
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async clear; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// Raster counters, sync generation and the pin output stage that realigns the
// engine's colour with sync/blank after the engine's pixel latency.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE     = VGA800_H_VISIBLE,
  parameter int H_FRONT       = VGA800_H_FRONT,
  parameter int H_SYNC        = VGA800_H_SYNC,
  parameter int H_BACK        = VGA800_H_BACK,
  parameter int V_VISIBLE     = VGA800_V_VISIBLE,
  parameter int V_FRONT       = VGA800_V_FRONT,
  parameter int V_SYNC        = VGA800_V_SYNC,
  parameter int V_BACK        = VGA800_V_BACK,
  parameter bit HS_POL        = VGA800_HS_POL,
  parameter bit VS_POL        = VGA800_VS_POL,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic                   VGA_CLOCK,
  input  logic                   RESET,
  vga_scan_controller_if.master  vga
);

  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        run_q, run_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic        active_q, active_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        vblank_q, vblank_d;
  logic [2:0]  dly;
  logic [2:0]  rgb_q, rgb_d;
  logic        hs_pin_q, hs_pin_d, vs_pin_q, vs_pin_d;

  // The first edge after reset only presents (0,0); counting begins on the next.
  always_comb begin
    run_d = 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
    active_d = (h_d < H_VIS) && (v_d < V_VIS);
    hs_d     = (h_d >= HS_START) && (h_d < HS_END);
    vs_d     = (v_d >= VS_START) && (v_d < VS_END);
    vblank_d = (h_d == '0) && (v_d == V_VIS);
  end

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      run_q    <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      active_q <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      h_q      <= h_d;
      v_q      <= v_d;
      active_q <= active_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vblank_q <= vblank_d;
    end
  end

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIXEL_LATENCY)
  ) u_flag_dly (
    .clk  (VGA_CLOCK),
    .rst  (RESET),
    .din  ({active_q, hs_q, vs_q}),
    .dout (dly)
  );

  // dly = {active, hsync, vsync}, already matched to the engine's colour latency
  always_comb begin
    rgb_d    = dly[2] ? vga.PIXEL : 3'b000;
    hs_pin_d = dly[1] ? HS_POL : ~HS_POL;
    vs_pin_d = dly[0] ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      rgb_q    <= 3'b000;
      hs_pin_q <= ~HS_POL;
      vs_pin_q <= ~VS_POL;
    end else begin
      rgb_q    <= rgb_d;
      hs_pin_q <= hs_pin_d;
      vs_pin_q <= vs_pin_d;
    end
  end

  assign vga.PIXEL_H      = h_q;
  assign vga.PIXEL_V      = v_q;
  assign vga.ACTIVE       = active_q;
  assign vga.VBLANK_START = vblank_q;
  assign vga.VGA_HS       = hs_pin_q;
  assign vga.VGA_VS       = vs_pin_q;
  assign vga.VGA_R        = rgb_q[RED];
  assign vga.VGA_G        = rgb_q[GREEN];
  assign vga.VGA_B        = rgb_q[BLUE];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Self-checking bench for vga_scan_controller on a shrunken raster so several
// frames fit in a short run; pin values are scoreboarded against a bench model.
module tb_vga_scan_controller;

  localparam int HV  = 16, HF = 2, HSY = 3, HB = 2;
  localparam int VV  = 6,  VF = 2, VSY = 2, VB = 1;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic VGA_CLOCK = 1'b0;
  logic RESET     = 1'b1;

  vga_scan_controller_if vga_if ();

  vga_scan_controller #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSY), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSY), .V_BACK (VB),
    .HS_POL (1'b1), .VS_POL (1'b1), .PIXEL_LATENCY (1)
  ) dut (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET     (RESET),
    .vga       (vga_if)
  );

  always #5 VGA_CLOCK = ~VGA_CLOCK;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } pins_t;

  pins_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    h_m, v_m, ph, pv;
  bit    m_run, p_valid;
  int    mode;
  int    cycle = 0;
  int    vb_count, hs_run, vs_run, last_start;

  function automatic bit m_act(int h, int v);
    return (h < HV) && (v < VV);
  endfunction
  function automatic bit m_hs(int h);
    return (h >= HV + HF) && (h < HV + HF + HSY);
  endfunction
  function automatic bit m_vs(int v);
    return (v >= VV + VF) && (v < VV + VF + VSY);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic release_reset();
    @(negedge VGA_CLOCK);
    RESET = 1'b0;
    m_run = 1'b0;
    p_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(pins_t'(0));
    vb_count = 0;
    hs_run = 0;
    vs_run = 0;
    last_start = -1;
  endtask

  task automatic tick();
    pins_t    e;
    pins_t    got;
    logic [2:0] p;
    @(posedge VGA_CLOCK);
    #1;
    cycle++;
    if (!m_run) begin
      h_m = 0; v_m = 0; m_run = 1'b1;
    end else if (h_m == HT - 1) begin
      h_m = 0;
      v_m = (v_m == VT - 1) ? 0 : v_m + 1;
    end else begin
      h_m = h_m + 1;
    end

    check("pixel_h", vga_if.PIXEL_H, h_m);
    check("pixel_v", vga_if.PIXEL_V, v_m);
    check("active", vga_if.ACTIVE, m_act(h_m, v_m));
    check("vblank_start", vga_if.VBLANK_START, (h_m == 0) && (v_m == VV));

    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {vga_if.VGA_R, vga_if.VGA_G, vga_if.VGA_B, vga_if.VGA_HS, vga_if.VGA_VS};
      check("pins_rgb_hs_vs", got, e);
    end else begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end

    case (mode)
      0:       p = 3'b111;
      1:       p = p_valid ? ph[2:0] : 3'b000;
      default: p = 3'($urandom_range(0, 7));
    endcase
    vga_if.PIXEL = p;
    e.rgb = (p_valid && m_act(ph, pv)) ? p : 3'b000;
    e.hs  = p_valid && m_hs(ph);
    e.vs  = p_valid && m_vs(pv);
    exp_q.push_back(e);
    ph = h_m; pv = v_m; p_valid = 1'b1;

    if (vga_if.VBLANK_START) vb_count++;
    if (vga_if.PIXEL_H == 11'd0 && vga_if.PIXEL_V == 11'd0) begin
      if (last_start >= 0) check("frame_period", cycle - last_start, FRAME);
      last_start = cycle;
    end
    if (vga_if.VGA_HS) hs_run++;
    else if (hs_run != 0) begin
      check("hs_width", hs_run, HSY);
      hs_run = 0;
    end
    if (vga_if.VGA_VS) vs_run++;
    else if (vs_run != 0) begin
      check("vs_width", vs_run, VSY * HT);
      vs_run = 0;
    end
  endtask

  initial begin
    vga_if.PIXEL = 3'b000;
    mode = 0;
    repeat (3) @(posedge VGA_CLOCK);
    #1;
    check("rst_pixel_h", vga_if.PIXEL_H, 0);
    check("rst_pixel_v", vga_if.PIXEL_V, 0);
    check("rst_active", vga_if.ACTIVE, 0);
    check("rst_vblank", vga_if.VBLANK_START, 0);
    check("rst_pins", {vga_if.VGA_R, vga_if.VGA_G, vga_if.VGA_B, vga_if.VGA_HS, vga_if.VGA_VS}, 0);

    // Three frames: all-white, engine echoing PIXEL_H[2:0], random colour
    release_reset();
    for (int f = 0; f < 3; f++) begin
      mode = f;
      for (int i = 0; i < FRAME; i++) tick();
    end
    check("vblank_pulses_3_frames", vb_count, 3);

    // Asynchronous reset in the middle of a visible line
    mode = 1;
    for (int i = 0; i < FRAME && !(h_m == 10 && v_m == 3); i++) tick();
    check("pre_reset_h", vga_if.PIXEL_H, 10);
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst_pixel_h", vga_if.PIXEL_H, 0);
    check("async_rst_pixel_v", vga_if.PIXEL_V, 0);
    check("async_rst_active", vga_if.ACTIVE, 0);
    check("async_rst_pins", {vga_if.VGA_R, vga_if.VGA_G, vga_if.VGA_B, vga_if.VGA_HS, vga_if.VGA_VS}, 0);
    release_reset();
    tick();
    check("first_edge_active", vga_if.ACTIVE, 1);
    tick();
    check("second_edge_h", vga_if.PIXEL_H, 1);

    mode = 2;
    for (int i = 2; i < 2 * FRAME; i++) tick();
    check("vblank_pulses_2_frames", vb_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
